// File: rtl/padding_row_sequencer.sv
// Row sequencer for the padding stage: walks one IMG_H-row frame, fetching each
// interior source row from line memory and handing padded rows to the conv buffer.
module padding_row_sequencer #(
   parameter int IMG_H = 416,
   parameter int CNT_W = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   output logic             rd_req,
   output logic [CNT_W-1:0] rd_row,
   input  logic             rd_valid,
   output logic             pad_en,
   output logic [CNT_W-1:0] pad_count,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_PAD,
      S_WAIT_OUT,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_pad_count;
   logic [CNT_W-1:0] w_pad_count_nxt;
   logic [CNT_W-1:0] w_count_inc;
   logic             w_last_row;

   assign w_count_inc = r_pad_count + CNT_W'(1);
   assign w_last_row  = (r_pad_count == LAST_ROW);

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_pad_count <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_pad_count <= w_pad_count_nxt;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt     = r_state;
      w_pad_count_nxt = r_pad_count;
      if (abort) begin
         w_state_nxt     = S_IDLE;
         w_pad_count_nxt = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // Row 0 is a zero border row, so a frame opens straight into PAD.
               if (start) begin
                  w_state_nxt     = S_PAD;
                  w_pad_count_nxt = '0;
               end
            end
            S_FETCH: begin
               if (rd_valid) begin
                  w_state_nxt = S_PAD;
               end
            end
            S_PAD: begin
               w_state_nxt = S_WAIT_OUT;
            end
            S_WAIT_OUT: begin
               if (out_ready) begin
                  if (w_last_row) begin
                     w_state_nxt = S_DONE;
                  end else begin
                     w_pad_count_nxt = w_count_inc;
                     w_state_nxt     = (w_count_inc == LAST_ROW) ? S_PAD : S_FETCH;
                  end
               end
            end
            S_DONE: begin
               w_state_nxt = S_IDLE;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      rd_req    = (r_state == S_FETCH);
      pad_en    = (r_state == S_PAD);
      out_valid = (r_state == S_WAIT_OUT);
      done      = (r_state == S_DONE);
      busy      = (r_state == S_FETCH) || (r_state == S_PAD) || (r_state == S_WAIT_OUT);
      pad_count = r_pad_count;
      // Interior output row k is built from source row k-1.
      rd_row    = rd_req ? (r_pad_count - CNT_W'(1)) : '0;
   end

endmodule
